// File: rtl/ym_bus_pkg.sv
// Shared encodings for the YM2151 host-side bus initiator.
package ym_bus_pkg;

    typedef enum logic [1:0] {StIdle, StPoll, StAddr, StData} ym_state_e;

    typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold, PhGap} ym_phase_e;

    localparam int unsigned BUSY_BIT = 7;
    localparam logic        A0_ADDR  = 1'b0;
    localparam logic        A0_DATA  = 1'b1;

endpackage

// File: rtl/ym_bus_cycle.sv
// Phase timer for one asynchronous bus cycle: SETUP, STROBE, HOLD, then a single GAP cycle.
module ym_bus_cycle
    import ym_bus_pkg::*;
#(
    parameter int unsigned T_SU = 1,
    parameter int unsigned T_PW = 4,
    parameter int unsigned T_HD = 2
) (
    input  logic      ymclk,
    input  logic      rst_n,
    input  logic      start,
    input  logic      is_read,
    output ym_phase_e phase,
    output logic      active,
    output logic      strobe_en,
    output logic      sample,
    output logic      last
);

    localparam int unsigned MaxT = (T_SU > T_PW) ? ((T_SU > T_HD) ? T_SU : T_HD)
                                                 : ((T_PW > T_HD) ? T_PW : T_HD);
    localparam int unsigned CntW = $clog2(MaxT + 1);

    ym_phase_e       phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            active_d = 1'b1;
            phase_d  = PhSetup;
            cnt_d    = CntW'(T_SU - 1);
        end else if (active_q) begin
            unique case (phase_q)
                PhSetup: begin
                    if (cnt_q == '0) begin
                        phase_d = PhStrobe;
                        cnt_d   = CntW'(T_PW - 1);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                PhStrobe: begin
                    if (cnt_q == '0) begin
                        phase_d = PhHold;
                        cnt_d   = CntW'(T_HD - 1);
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                PhHold: begin
                    if (cnt_q == '0) begin
                        phase_d = PhGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                PhGap: active_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PhSetup;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // phase/active/strobe_en describe the coming cycle so the host can register its pins from them
    assign phase     = phase_d;
    assign active    = active_d;
    assign strobe_en = active_d && (phase_d == PhStrobe);
    assign sample    = active_q && is_read && (phase_q == PhStrobe) && (cnt_q == '0);
    assign last      = active_q && (phase_q == PhGap);

endmodule

// File: rtl/ym_bus_host.sv
// Host-side YM2151 CPU-port initiator: polls busy, then writes address and data per request.
module ym_bus_host
    import ym_bus_pkg::*;
#(
    parameter int unsigned T_SU       = 1,
    parameter int unsigned T_PW       = 4,
    parameter int unsigned T_HD       = 2,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic       ymclk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       done,
    output logic       err,
    output logic [7:0] last_status,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

    ym_state_e       state_q, state_d;
    logic [7:0]      addr_q, data_q, ls_q, ls_d, dout_q, dout_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic            ready_q, done_q, done_d, err_q, err_d;
    logic            cs_n_q, wr_n_q, rd_n_q, a0_q, oe_q, a0_d;
    logic            accept, start, drive;
    ym_phase_e       phase_n;
    logic            active_n, strobe_en, sample, last;

    ym_bus_cycle #(
        .T_SU(T_SU),
        .T_PW(T_PW),
        .T_HD(T_HD)
    ) u_cycle (
        .ymclk    (ymclk),
        .rst_n    (rst_n),
        .start    (start),
        .is_read  (state_q == StPoll),
        .phase    (phase_n),
        .active   (active_n),
        .strobe_en(strobe_en),
        .sample   (sample),
        .last     (last)
    );

    assign accept = (state_q == StIdle) && ready_q && req_valid;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        poll_d  = poll_q;
        ls_d    = ls_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StPoll;
                    start   = 1'b1;
                    poll_d  = '0;
                end
            end
            StPoll: begin
                if (sample) begin
                    ls_d   = bus_din;
                    poll_d = poll_q + PollW'(1);
                end
                if (last) begin
                    if (!ls_q[BUSY_BIT]) begin
                        state_d = StAddr;
                        start   = 1'b1;
                    end else if (poll_q >= PollW'(POLL_LIMIT)) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end else begin
                        start = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (last) begin
                    state_d = StData;
                    start   = 1'b1;
                end
            end
            StData: begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Pin values for the coming cycle; a0 and bus_dout keep their value through GAP and IDLE
    always_comb begin
        drive  = active_n && (phase_n != PhGap);
        a0_d   = a0_q;
        dout_d = dout_q;
        if (drive) begin
            a0_d = (state_d == StData) ? A0_DATA : A0_ADDR;
            if (state_d == StAddr) dout_d = addr_q;
            if (state_d == StData) dout_d = data_q;
        end
    end

    always_ff @(posedge ymclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            poll_q  <= '0;
            ls_q    <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_data;
            end
            poll_q  <= poll_d;
            ls_q    <= ls_d;
            ready_q <= (state_d == StIdle);
            done_q  <= done_d;
            err_q   <= err_d;
            cs_n_q  <= !drive;
            rd_n_q  <= !(strobe_en && (state_d == StPoll));
            wr_n_q  <= !(strobe_en && ((state_d == StAddr) || (state_d == StData)));
            a0_q    <= a0_d;
            oe_q    <= drive && (state_d != StPoll);
            dout_q  <= dout_d;
        end
    end

    assign req_ready   = ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign last_status = ls_q;
    assign cs_n        = cs_n_q;
    assign wr_n        = wr_n_q;
    assign rd_n        = rd_n_q;
    assign a0          = a0_q;
    assign bus_oe      = oe_q;
    assign bus_dout    = dout_q;

endmodule

// File: tb/tb_ym_bus_host.sv
// Bench for ym_bus_host: cycle-level timing model plus directed literal checks on three configurations.
module tb_ym_bus_host;

    logic ymclk = 1'b0;
    logic rst_n = 1'b1;
    always #5 ymclk = ~ymclk;

    logic       rv [3];
    logic [7:0] req_addr, req_data, bus_din;
    logic       ready_w [3], done_w [3], err_w [3], cs_w [3], wr_w [3], rd_w [3];
    logic       a0_w [3], oe_w [3];
    logic [7:0] ls_w [3], dout_w [3];

    ym_bus_host u_dut0 (
        .ymclk(ymclk), .rst_n(rst_n), .req_valid(rv[0]), .req_addr(req_addr),
        .req_data(req_data), .req_ready(ready_w[0]), .done(done_w[0]), .err(err_w[0]),
        .last_status(ls_w[0]), .cs_n(cs_w[0]), .wr_n(wr_w[0]), .rd_n(rd_w[0]), .a0(a0_w[0]),
        .bus_dout(dout_w[0]), .bus_oe(oe_w[0]), .bus_din(bus_din)
    );

    ym_bus_host #(.POLL_LIMIT(4)) u_dut1 (
        .ymclk(ymclk), .rst_n(rst_n), .req_valid(rv[1]), .req_addr(req_addr),
        .req_data(req_data), .req_ready(ready_w[1]), .done(done_w[1]), .err(err_w[1]),
        .last_status(ls_w[1]), .cs_n(cs_w[1]), .wr_n(wr_w[1]), .rd_n(rd_w[1]), .a0(a0_w[1]),
        .bus_dout(dout_w[1]), .bus_oe(oe_w[1]), .bus_din(bus_din)
    );

    ym_bus_host #(.T_SU(3), .T_PW(1), .T_HD(1)) u_dut2 (
        .ymclk(ymclk), .rst_n(rst_n), .req_valid(rv[2]), .req_addr(req_addr),
        .req_data(req_data), .req_ready(ready_w[2]), .done(done_w[2]), .err(err_w[2]),
        .last_status(ls_w[2]), .cs_n(cs_w[2]), .wr_n(wr_w[2]), .rd_n(rd_w[2]), .a0(a0_w[2]),
        .bus_dout(dout_w[2]), .bus_oe(oe_w[2]), .bus_din(bus_din)
    );

    function automatic int p_su(input int s);  return (s == 2) ? 3 : 1;    endfunction
    function automatic int p_pw(input int s);  return (s == 2) ? 1 : 4;    endfunction
    function automatic int p_hd(input int s);  return (s == 2) ? 1 : 2;    endfunction
    function automatic int p_lim(input int s); return (s == 1) ? 4 : 1024; endfunction

    int sel = 0;
    int busy_reads = 0;
    int total_reads = 0;
    int base_reads = 0;
    int errors = 0;
    int checks = 0;
    int cyc_neg = 0;

    // Status chip: reads 1..busy_reads of the current test report busy
    logic cur_rd;
    assign cur_rd  = rd_w[sel];
    always @(negedge cur_rd) total_reads++;
    assign bus_din = ((total_reads - base_reads) <= busy_reads) ? 8'h80 : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc_neg, act, exp);
        end
    endtask

    int         done_log[$], err_log[$], wr_log[$], rd_log[$];
    logic [7:0] wdat_log[$];
    logic       p_wr = 1'b1, p_rd = 1'b1;

    // Model: 0 = reset/first cycle after release, 1 = idle, 2 = transaction at cycle m_c
    int         m_st = 0, m_c = 0, m_n = 0, m_end = 0, m_busy = 0;
    logic       m_to = 1'b0, m_a0 = 1'b0;
    logic [7:0] m_addr = 8'h00, m_data = 8'h00, m_ls = 8'h00, m_ls_prev = 8'h00;

    always @(negedge ymclk) begin : cmp
        int L, su, pw, b, o, k, lim;
        logic e_ready, e_done, e_err, e_cs, e_wr, e_rd, e_a0, e_oe, gap, wcyc, strb, dchk;
        logic [7:0] e_ls, e_dout;
        cyc_neg++;
        su = p_su(sel);
        pw = p_pw(sel);
        L  = su + pw + p_hd(sel) + 1;
        if (!rst_n) begin
            m_st = 0;
            m_a0 = 1'b0;
            m_ls = 8'h00;
        end
        e_ready = 0; e_done = 0; e_err = 0; e_cs = 1; e_wr = 1; e_rd = 1; e_oe = 0;
        e_a0 = m_a0; e_ls = m_ls; e_dout = 8'h00; dchk = 0;
        if (m_st == 0) begin
            dchk = 1;
        end else if (m_st == 1) begin
            e_ready = 1;
        end else begin
            k = 0;
            for (int i = 0; i < m_n; i++) if (m_c >= i * L + su + pw) k++;
            e_ls = (k == 0) ? m_ls_prev : (((k - 1) < m_busy) ? 8'h80 : 8'h00);
            if (m_c == m_end) begin
                e_ready = 1;
                e_done  = !m_to;
                e_err   = m_to;
            end else begin
                b = m_c / L;
                o = m_c % L;
                gap  = (o == L - 1);
                wcyc = (b >= m_n);
                strb = (o >= su) && (o < su + pw);
                e_cs = gap;
                e_rd = !(strb && !wcyc);
                e_wr = !(strb && wcyc);
                e_oe = wcyc && !gap;
                if (!gap) e_a0 = (b == m_n + 1);
                e_dout = (b == m_n) ? m_addr : m_data;
                dchk = e_oe;
            end
        end
        chk("req_ready", ready_w[sel], e_ready);
        chk("done", done_w[sel], e_done);
        chk("err", err_w[sel], e_err);
        chk("cs_n", cs_w[sel], e_cs);
        chk("wr_n", wr_w[sel], e_wr);
        chk("rd_n", rd_w[sel], e_rd);
        chk("a0", a0_w[sel], e_a0);
        chk("bus_oe", oe_w[sel], e_oe);
        chk("last_status", ls_w[sel], e_ls);
        if (dchk) chk("bus_dout", dout_w[sel], e_dout);
        chk("inv_wr_rd", !wr_w[sel] && !rd_w[sel], 0);
        chk("inv_oe_rd", oe_w[sel] && !rd_w[sel], 0);
        chk("inv_strobe_cs", cs_w[sel] && (!wr_w[sel] || !rd_w[sel]), 0);
        if (rst_n) begin
            if (done_w[sel]) done_log.push_back(cyc_neg);
            if (err_w[sel]) err_log.push_back(cyc_neg);
            if (p_wr && !wr_w[sel]) begin
                wr_log.push_back(cyc_neg);
                wdat_log.push_back(dout_w[sel]);
            end
            if (p_rd && !rd_w[sel]) rd_log.push_back(cyc_neg);
        end
        p_wr = wr_w[sel];
        p_rd = rd_w[sel];
        m_a0 = e_a0;
        if (rst_n) begin
            if ((m_st == 1 || (m_st == 2 && m_c == m_end)) && rv[sel]) begin
                m_ls_prev = e_ls;
                m_st   = 2;
                m_c    = 0;
                m_addr = req_addr;
                m_data = req_data;
                m_busy = busy_reads;
                lim    = p_lim(sel);
                m_to   = (busy_reads >= lim);
                m_n    = m_to ? lim : busy_reads + 1;
                m_end  = m_to ? m_n * L : (m_n + 2) * L;
            end else if (m_st == 0) begin
                m_st = 1;
            end else if (m_st == 2) begin
                if (m_c == m_end) begin
                    m_st = 1;
                    m_ls = e_ls;
                end else begin
                    m_c++;
                end
            end
        end
    end

    function automatic int n_since(input int q[$], input int from);
        int n = 0;
        foreach (q[i]) if (q[i] >= from) n++;
        return n;
    endfunction

    function automatic int idx_since(input int q[$], input int from);
        foreach (q[i]) if (q[i] >= from) return i;
        return -1;
    endfunction

    function automatic int first_since(input int q[$], input int from);
        foreach (q[i]) if (q[i] >= from) return q[i] - from;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge ymclk);
        #2 rst_n = 1'b1;
        @(posedge ymclk);
        #1;
    endtask

    task automatic issue(input int s, input logic [7:0] a, input logic [7:0] d,
                         input int busy, output int acc);
        base_reads = total_reads;
        busy_reads = busy;
        req_addr   = a;
        req_data   = d;
        rv[s]      = 1'b1;
        @(posedge ymclk);
        #1 rv[s] = 1'b0;
        acc = cyc_neg + 1;
    endtask

    initial begin
        int acc, acc2, rst_at, i;
        rv = '{1'b0, 1'b0, 1'b0};
        req_addr = 8'h00;
        req_data = 8'h00;
        #1 rst_n = 1'b0;

        // Idle status
        sel = 0;
        do_reset();
        issue(0, 8'h20, 8'hC7, 0, acc);
        repeat (30) @(posedge ymclk);
        #1;
        chk("t1_done_cycle", first_since(done_log, acc), 24);
        chk("t1_first_wr", first_since(wr_log, acc), 9);
        chk("t1_reads", n_since(rd_log, acc), 1);
        chk("t1_writes", n_since(wr_log, acc), 2);
        chk("t1_errs", n_since(err_log, acc), 0);
        i = idx_since(wr_log, acc);
        chk("t1_addr_byte", wdat_log[i], 8'h20);
        chk("t1_data_byte", wdat_log[i+1], 8'hC7);
        chk("t1_status", ls_w[0], 8'h00);

        // Busy for three reads
        issue(0, 8'h20, 8'hC7, 3, acc);
        repeat (55) @(posedge ymclk);
        #1;
        chk("t2_done_cycle", first_since(done_log, acc), 48);
        chk("t2_first_wr", first_since(wr_log, acc), 33);
        chk("t2_reads", n_since(rd_log, acc), 4);
        chk("t2_status", ls_w[0], 8'h00);

        // Poll timeout
        sel = 1;
        do_reset();
        issue(1, 8'h11, 8'h22, 1000, acc);
        repeat (40) @(posedge ymclk);
        #1;
        chk("t3_err_cycle", first_since(err_log, acc), 32);
        chk("t3_reads", n_since(rd_log, acc), 4);
        chk("t3_writes", n_since(wr_log, acc), 0);
        chk("t3_dones", n_since(done_log, acc), 0);
        chk("t3_ready", ready_w[1], 1'b1);
        chk("t3_status", ls_w[1], 8'h80);

        // Back-to-back
        sel = 0;
        do_reset();
        base_reads = total_reads;
        busy_reads = 0;
        req_addr = 8'h08;
        req_data = 8'h78;
        rv[0] = 1'b1;
        @(posedge ymclk);
        #1 acc = cyc_neg + 1;
        req_addr = 8'h28;
        req_data = 8'h4A;
        repeat (25) @(posedge ymclk);
        #1 rv[0] = 1'b0;
        repeat (30) @(posedge ymclk);
        #1;
        i = idx_since(done_log, acc);
        chk("t4_done1_cycle", first_since(done_log, acc), 24);
        chk("t4_done2_cycle", done_log[i+1] - acc, 49);
        chk("t4_dones", n_since(done_log, acc), 2);
        chk("t4_writes", n_since(wr_log, acc), 4);
        i = idx_since(wr_log, acc);
        chk("t4_byte0", wdat_log[i], 8'h08);
        chk("t4_byte1", wdat_log[i+1], 8'h78);
        chk("t4_byte2", wdat_log[i+2], 8'h28);
        chk("t4_byte3", wdat_log[i+3], 8'h4A);

        // Reset during the address strobe
        issue(0, 8'h55, 8'hAA, 0, acc);
        repeat (10) @(posedge ymclk);
        #2 chk("t5_wr_low_before", wr_w[0], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_cs_n", cs_w[0], 1'b1);
        chk("t5_wr_n", wr_w[0], 1'b1);
        chk("t5_rd_n", rd_w[0], 1'b1);
        chk("t5_oe", oe_w[0], 1'b0);
        chk("t5_ready", ready_w[0], 1'b0);
        rst_at = cyc_neg;
        repeat (2) @(posedge ymclk);
        #2 rst_n = 1'b1;
        chk("t5_ready_pre_edge", ready_w[0], 1'b0);
        @(posedge ymclk);
        #1 chk("t5_ready_post_edge", ready_w[0], 1'b1);
        issue(0, 8'h30, 8'h5A, 0, acc2);
        repeat (30) @(posedge ymclk);
        #1;
        chk("t5_dones", n_since(done_log, rst_at), 1);
        chk("t5_done_cycle", first_since(done_log, acc2), 24);
        i = idx_since(wr_log, acc2);
        chk("t5_addr_byte", wdat_log[i], 8'h30);
        chk("t5_data_byte", wdat_log[i+1], 8'h5A);

        // Timing sweep
        sel = 2;
        do_reset();
        issue(2, 8'h40, 8'h1F, 0, acc);
        repeat (25) @(posedge ymclk);
        #1;
        chk("t6_done_cycle", first_since(done_log, acc), 18);
        chk("t6_first_wr", first_since(wr_log, acc), 9);
        chk("t6_writes", n_since(wr_log, acc), 2);
        chk("t6_status", ls_w[2], 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ym_bus_host.md
# ym_bus_host

Host-side bus initiator for the YM2151-compatible CPU port: the block that drives `cs_n`/`wr_n`/`rd_n`/`a0`/`data` into the chip (or the FPGA jt51 wrapper) instead of receiving them. It accepts one register write per request from a sequencer or soft-CPU, polls the status busy flag, then issues the address write and the data write with programmable asynchronous-bus timing. It sits in the host/test FPGA and is also the stimulus master for board-level tests of the OPM core.

## Interface
- `T_SU`, 1: setup cycles; `cs_n` low, `a0` and data valid before the strobe falls (≥1).
- `T_PW`, 4: strobe (`wr_n`/`rd_n`) low width in cycles (≥1).
- `T_HD`, 2: hold cycles after the strobe rises, with `cs_n` still low and data still driven (≥1).
- `POLL_LIMIT`, 1024: maximum busy-status reads per request before abort (≥1).

Ports:
- `ymclk` in 1: clock. All outputs are registered on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_addr` in 8: YM register address.
- `req_data` in 8: register value.
- `req_ready` out 1: block is idle and can accept a request.
- `done` out 1: one-cycle pulse when the data write completes.
- `err` out 1: one-cycle pulse when the poll times out.
- `last_status` out 8: last status byte read.
- `cs_n`, `wr_n`, `rd_n` out 1 each: bus strobes, active-low.
- `a0` out 1: 0 selects address or status, 1 selects data.
- `bus_dout` out 8: write data.
- `bus_oe` out 1: enable for the bidirectional data pad driver.
- `bus_din` in 8: pad input. It is sampled only as described below.

## Operation
- States: IDLE, POLL, ADDR, DATA. Each non-IDLE state runs one bus cycle with phases SETUP (T_SU), STROBE (T_PW), HOLD (T_HD), GAP (1).
- Accepting a request:
  - A request is accepted on the edge where `req_valid & req_ready`.
  - `req_addr` and `req_data` are captured at that edge.
  - The state goes to POLL.
- POLL bus cycle: `a0=0`, `bus_oe=0`, `rd_n` is the strobe.
  - `bus_din` is captured into `last_status` on the edge that ends the last STROBE cycle.
  - After GAP, if `last_status[7]` = 1 (busy), POLL repeats. Otherwise the state goes to ADDR.
  - The poll counter increments per read. When the POLL_LIMIT-th read still shows busy, `err` pulses, no write is issued, and the state returns to IDLE.
- ADDR bus cycle: `a0=0`, `bus_dout=addr`, `bus_oe=1` through SETUP, STROBE and HOLD. `wr_n` is the strobe.
- DATA bus cycle: same as ADDR with `a0=1` and `bus_dout=data`. After its GAP, `done` pulses and the state returns to IDLE.
- GAP: `cs_n=1`, `bus_oe=0`, and `a0` holds its previous value.
- Invariants:
  - `wr_n` and `rd_n` are never low simultaneously.
  - `bus_oe` is never 1 while `rd_n`=0.
  - A strobe is never low while `cs_n`=1.
- Reset: async assert forces `cs_n=wr_n=rd_n=1`, `a0=0`, `bus_oe=0`, `bus_dout=0`, `req_ready=0`, `done=err=0`, `last_status=0`, and state IDLE.
  - This applies mid-strobe too: any in-flight request is dropped and no completion is reported.

## Timing
- Bus-cycle length is L = T_SU+T_PW+T_HD+1 cycles. With the defaults, L = 8.
- `cs_n` falls at the accepting edge, so cycle 0 is the first SETUP cycle.
- Transaction with n polls: `done` is high in cycle (n+2)·L after accept. `req_ready` rises in that same cycle.
- `req_ready` rises on the first edge after `rst_n` deasserts.
- `req_ready` is 0 from the accepting edge until `done`/`err`.
- A request held valid during the `done` cycle is accepted then, giving back-to-back operation with no extra idle cycle.
- `req_valid` while `req_ready`=0 is ignored. Inputs are not sampled.

## Structure
- Package `ym_bus_pkg` holds:
  - the state encoding (IDLE/POLL/ADDR/DATA);
  - the phase encoding (SETUP/STROBE/HOLD/GAP);
  - `BUSY_BIT=7`;
  - `A0_ADDR=0` and `A0_DATA=1`.
- Sub-module `ym_bus_cycle`:
  - contains the phase timer;
  - takes `start`, `is_read`, `T_SU/T_PW/T_HD`;
  - outputs phase, strobe enable, `sample` and `last`.
- The top FSM instantiates `ym_bus_cycle` once. Total size is about 200 lines.

## Test plan
- Idle status: req (0x20, 0xC7), `bus_din`=0x00.
  - Expect one `rd_n` pulse of 4 cycles, then `a0=0`/0x20 with `wr_n` low in cycles 9–12, then `a0=1`/0xC7 with `wr_n` low in cycles 17–20.
  - `done` is high in cycle 24, `err` stays 0 and `last_status`=0x00.
- Busy: `bus_din`=0x80 for the first 3 reads, then 0x00.
  - Expect 4 POLL cycles, with writes starting at cycle 32.
  - `done` is high in cycle 48 and `last_status`=0x00.
- Timeout: `POLL_LIMIT`=4, `bus_din` stuck at 0x80.
  - Expect exactly 4 reads and `err` high in cycle 32.
  - `wr_n` never falls, `done` stays 0 and `req_ready` returns.
- Back-to-back: `req_valid` held high with (0x08, 0x78) then (0x28, 0x4A).
  - Second accept happens in the `done` cycle of the first.
  - Expect 6 bus cycles, no idle gap, and the data order 0x08, 0x78, 0x28, 0x4A.
- Reset mid-strobe: assert `rst_n`=0 during the ADDR STROBE.
  - All strobes go high and `bus_oe`=0 immediately, with no `done`.
  - After release, `req_ready`=1 on the next edge and a fresh request completes normally.
- Timing sweep: `T_SU`=3, `T_PW`=1, `T_HD`=1, idle status.
  - L=6, and `done` is high in cycle 18.
  - Assertions check all the invariants throughout.
